// File: rtl/regs_wb_arbiter_if.sv
// Writeback arbiter bus: two writeback requesters, decode scoreboard alloc/lookup,
// and the registered register-file write port.
interface regs_wb_arbiter_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);

  // Requester 0: ALU result
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  // Requester 1: load data
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  // Decode: mark destination pending, look up source hazards
  logic              alloc_en;
  logic [ADDR_W-1:0] alloc_addr;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic              rs1_busy;
  logic              rs2_busy;

  // Register file write port
  logic              reg_write_en;
  logic [ADDR_W-1:0] reg_waddr;
  logic [DATA_W-1:0] reg_wdata;

  // Pipeline side: requesters, decode, and the register file observer
  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output alloc_en, alloc_addr, rs1_addr, rs2_addr,
    input  req0_ready, req1_ready, rs1_busy, rs2_busy,
    input  reg_write_en, reg_waddr, reg_wdata
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  alloc_en, alloc_addr, rs1_addr, rs2_addr,
    output req0_ready, req1_ready, rs1_busy, rs2_busy,
    output reg_write_en, reg_waddr, reg_wdata
  );

endinterface

// File: rtl/regs_wb_arbiter.sv
// Register-file writeback arbiter: shares the single write port between the ALU
// (req0) and load (req1) writeback paths, and keeps a pending-write scoreboard
// so decode can stall on sources whose producer has not written back yet.
module regs_wb_arbiter #(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned DATA_W      = 32,
  parameter bit          ROUND_ROBIN = 1'b1
) (
  input logic             clk,
  input logic             rst,
  regs_wb_arbiter_if.slave bus
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  // 1: req1 won the most recent transfer, 0: req0 did
  logic              last_grant_q, last_grant_d;
  logic              grant0, grant1, xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic [NumRegs-1:0] pending_q, pending_d;

  logic              write_en_q, write_en_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Arbitration: a lone requester always wins; a contest goes by round-robin or to req0
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    unique case ({bus.req1_valid, bus.req0_valid})
      2'b01: grant0 = 1'b1;
      2'b10: grant1 = 1'b1;
      2'b11: begin
        if (ROUND_ROBIN && !last_grant_q) grant1 = 1'b1;
        else                              grant0 = 1'b1;
      end
      default: ;
    endcase
  end

  assign xfer     = grant0 | grant1;
  assign sel_addr = grant1 ? bus.req1_addr : bus.req0_addr;
  assign sel_data = grant1 ? bus.req1_data : bus.req0_data;

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // Next-state: grant history, write port staging and scoreboard update
  always_comb begin
    last_grant_d = last_grant_q;
    write_en_d   = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    pending_d    = pending_q;

    if (xfer) begin
      last_grant_d       = grant1;
      // x0 writes are accepted so the requester retires, but never reach the regfile
      write_en_d         = (sel_addr != '0);
      waddr_d            = sel_addr;
      wdata_d            = sel_data;
      pending_d[sel_addr] = 1'b0;
    end

    // A new producer allocated on the retire edge stays outstanding
    if (bus.alloc_en) begin
      pending_d[bus.alloc_addr] = 1'b1;
    end

    pending_d[0] = 1'b0;
  end

  // State registers; reset drops any grant presented in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      write_en_q   <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      pending_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      write_en_q   <= write_en_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      pending_q    <= pending_d;
    end
  end

  // Pending clears on the accept edge, so a reader unstalls in the cycle the
  // regfile sees the write and can forward it.
  assign bus.rs1_busy = pending_q[bus.rs1_addr];
  assign bus.rs2_busy = pending_q[bus.rs2_addr];

  assign bus.reg_write_en = write_en_q;
  assign bus.reg_waddr    = waddr_q;
  assign bus.reg_wdata    = wdata_q;

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Bench for regs_wb_arbiter: one round-robin and one fixed-priority instance,
// directed scenarios with literal expectations, then randomized traffic checked
// every cycle against a behavioural model.
module tb_regs_wb_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          alloc_en;
    logic [AW-1:0] alloc_addr;
    logic [AW-1:0] rs1_addr;
    logic [AW-1:0] rs2_addr;
  } stim_t;

  typedef struct packed {
    logic          req0_ready;
    logic          req1_ready;
    logic          rs1_busy;
    logic          rs2_busy;
    logic          reg_write_en;
    logic [AW-1:0] reg_waddr;
    logic [DW-1:0] reg_wdata;
  } obs_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  stim_t st [2];
  bit    chk_en = 1'b0;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  // Instance 0: round-robin, instance 1: fixed priority
  for (genvar g = 0; g < 2; g++) begin : g_dut
    regs_wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) u_if ();
    obs_t obs;

    assign u_if.req0_valid = st[g].req0_valid;
    assign u_if.req0_addr  = st[g].req0_addr;
    assign u_if.req0_data  = st[g].req0_data;
    assign u_if.req1_valid = st[g].req1_valid;
    assign u_if.req1_addr  = st[g].req1_addr;
    assign u_if.req1_data  = st[g].req1_data;
    assign u_if.alloc_en   = st[g].alloc_en;
    assign u_if.alloc_addr = st[g].alloc_addr;
    assign u_if.rs1_addr   = st[g].rs1_addr;
    assign u_if.rs2_addr   = st[g].rs2_addr;

    assign obs = {u_if.req0_ready, u_if.req1_ready, u_if.rs1_busy, u_if.rs2_busy,
                  u_if.reg_write_en, u_if.reg_waddr, u_if.reg_wdata};

    regs_wb_arbiter #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .ROUND_ROBIN(g == 0)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(u_if)
    );
  end

  // ---------------- behavioural model ----------------
  bit [31:0]     m_pend  [2];
  int            m_last  [2];   // index of the requester that last transferred
  bit            m_we    [2];
  logic [AW-1:0] m_waddr [2];
  logic [DW-1:0] m_wdata [2];
  bit            acc0    [2];   // request accepted at the most recent edge
  bit            acc1    [2];

  // Which requester is granted: -1 none, 0 or 1
  function automatic int winner(bit v0, bit v1, int last, bit rr);
    if (v0 && v1) return rr ? (last == 0 ? 1 : 0) : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    for (int i = 0; i < 2; i++) begin
      w = winner(st[i].req0_valid, st[i].req1_valid, m_last[i], i == 0);
      if (rst) begin
        m_pend[i]  = '0;
        m_last[i]  = 1;
        m_we[i]    = 1'b0;
        m_waddr[i] = '0;
        m_wdata[i] = '0;
        acc0[i]    = 1'b0;
        acc1[i]    = 1'b0;
      end else begin
        acc0[i] = (w == 0);
        acc1[i] = (w == 1);
        m_we[i] = 1'b0;
        if (w >= 0) begin
          m_last[i]  = w;
          m_waddr[i] = (w == 0) ? st[i].req0_addr : st[i].req1_addr;
          m_wdata[i] = (w == 0) ? st[i].req0_data : st[i].req1_data;
          m_we[i]    = (m_waddr[i] != 0);
          m_pend[i][m_waddr[i]] = 1'b0;
        end
        if (st[i].alloc_en && st[i].alloc_addr != 0) m_pend[i][st[i].alloc_addr] = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare(input int i, input obs_t o);
    string p;
    int    w;
    p = (i == 0) ? "rr" : "fp";
    w = winner(st[i].req0_valid, st[i].req1_valid, m_last[i], i == 0);
    chk({p, ".req0_ready"}, o.req0_ready, w == 0);
    chk({p, ".req1_ready"}, o.req1_ready, w == 1);
    chk({p, ".rs1_busy"}, o.rs1_busy, m_pend[i][st[i].rs1_addr]);
    chk({p, ".rs2_busy"}, o.rs2_busy, m_pend[i][st[i].rs2_addr]);
    chk({p, ".reg_write_en"}, o.reg_write_en, m_we[i]);
    chk({p, ".reg_waddr"}, o.reg_waddr, m_waddr[i]);
    chk({p, ".reg_wdata"}, o.reg_wdata, m_wdata[i]);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      compare(0, g_dut[0].obs);
      compare(1, g_dut[1].obs);
    end
  end

  // ---------------- stimulus ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input stim_t s);
    st[0] = s;
    st[1] = s;
  endtask

  task automatic drive_random(input int i);
    stim_t s;
    s = st[i];
    if (!(s.req0_valid && !acc0[i])) begin
      s.req0_valid = ($urandom_range(0, 2) != 0);
      s.req0_addr  = AW'($urandom_range(0, 7));
      s.req0_data  = $urandom;
    end
    if (!(s.req1_valid && !acc1[i])) begin
      s.req1_valid = ($urandom_range(0, 2) != 0);
      s.req1_addr  = AW'($urandom_range(0, 7));
      s.req1_data  = $urandom;
    end
    s.alloc_en   = ($urandom_range(0, 2) == 0);
    s.alloc_addr = AW'($urandom_range(0, 7));
    s.rs1_addr   = AW'($urandom_range(0, 7));
    s.rs2_addr   = AW'($urandom_range(0, 7));
    st[i] = s;
  endtask

  initial begin
    stim_t s;
    s = '0;
    set_all(s);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    // Reset then idle
    s.rs1_addr = 5;
    s.rs2_addr = 7;
    set_all(s);
    @(negedge clk);
    chk("lit.reset.we", g_dut[0].obs.reg_write_en, 0);
    chk("lit.reset.busy", {g_dut[0].obs.rs1_busy, g_dut[0].obs.rs2_busy}, 0);
    chk("lit.reset.ready", {g_dut[0].obs.req0_ready, g_dut[0].obs.req1_ready}, 0);

    // Allocate x5, then req0 retires it
    next();
    s = '0; s.alloc_en = 1; s.alloc_addr = 5; s.rs1_addr = 5;
    set_all(s);
    next();
    s = '0; s.req0_valid = 1; s.req0_addr = 5; s.req0_data = 32'h1234; s.rs1_addr = 5;
    set_all(s);
    @(negedge clk);
    chk("lit.alloc.busy", g_dut[0].obs.rs1_busy, 1);
    chk("lit.alloc.ready0", g_dut[0].obs.req0_ready, 1);
    next();
    s.req0_valid = 0;
    set_all(s);
    @(negedge clk);
    chk("lit.wb.we", g_dut[0].obs.reg_write_en, 1);
    chk("lit.wb.waddr", g_dut[0].obs.reg_waddr, 5);
    chk("lit.wb.wdata", g_dut[0].obs.reg_wdata, 32'h1234);
    chk("lit.wb.busy", g_dut[0].obs.rs1_busy, 0);

    // Contest for four cycles from a fresh reset
    next();
    rst = 1'b1;
    s = '0;
    set_all(s);
    next();
    rst = 1'b0;
    s = '0;
    s.req0_valid = 1; s.req0_addr = 3; s.req0_data = 32'hA;
    s.req1_valid = 1; s.req1_addr = 4; s.req1_data = 32'hB;
    set_all(s);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lit.rr.ready0", g_dut[0].obs.req0_ready, (k % 2 == 0) ? 1 : 0);
      chk("lit.rr.ready1", g_dut[0].obs.req1_ready, (k % 2 == 1) ? 1 : 0);
      chk("lit.fp.ready0", g_dut[1].obs.req0_ready, 1);
      chk("lit.fp.ready1", g_dut[1].obs.req1_ready, 0);
      if (k > 0) begin
        chk("lit.rr.waddr", g_dut[0].obs.reg_waddr, ((k - 1) % 2 == 0) ? 3 : 4);
        chk("lit.fp.waddr", g_dut[1].obs.reg_waddr, 3);
      end
      next();
    end
    s = '0;
    set_all(s);
    @(negedge clk);
    chk("lit.rr.waddr_last", g_dut[0].obs.reg_waddr, 4);
    chk("lit.rr.we_last", g_dut[0].obs.reg_write_en, 1);

    // Write to x0 and allocation of x0
    next();
    s = '0; s.req1_valid = 1; s.req1_addr = 0; s.req1_data = 32'hFFFF;
    s.alloc_en = 1; s.alloc_addr = 0; s.rs1_addr = 0;
    set_all(s);
    @(negedge clk);
    chk("lit.x0.ready1", g_dut[0].obs.req1_ready, 1);
    next();
    s = '0;
    set_all(s);
    @(negedge clk);
    chk("lit.x0.we", g_dut[0].obs.reg_write_en, 0);
    chk("lit.x0.busy", g_dut[0].obs.rs1_busy, 0);

    // Re-allocation of x7 on the edge it retires keeps it pending
    next();
    s = '0; s.alloc_en = 1; s.alloc_addr = 7; s.rs1_addr = 7;
    set_all(s);
    next();
    s.req0_valid = 1; s.req0_addr = 7; s.req0_data = 32'h77;
    set_all(s);
    @(negedge clk);
    chk("lit.x7.busy_before", g_dut[0].obs.rs1_busy, 1);
    next();
    s = '0; s.rs1_addr = 7;
    set_all(s);
    @(negedge clk);
    chk("lit.x7.busy_after", g_dut[0].obs.rs1_busy, 1);
    chk("lit.x7.we", g_dut[0].obs.reg_write_en, 1);
    chk("lit.x7.waddr", g_dut[0].obs.reg_waddr, 7);

    // Reset during a contest discards the grant and restarts round-robin at req0
    next();
    s = '0; s.alloc_en = 1; s.alloc_addr = 9; s.rs1_addr = 9;
    s.req0_valid = 1; s.req0_addr = 2; s.req0_data = 32'h22;
    set_all(s);
    next();
    rst = 1'b1;
    s = '0; s.rs1_addr = 9;
    s.req0_valid = 1; s.req0_addr = 3; s.req0_data = 32'hA;
    s.req1_valid = 1; s.req1_addr = 4; s.req1_data = 32'hB;
    set_all(s);
    @(negedge clk);
    chk("lit.rst.busy_before", g_dut[0].obs.rs1_busy, 1);
    chk("lit.rst.ready1_before", g_dut[0].obs.req1_ready, 1);
    next();
    rst = 1'b0;
    @(negedge clk);
    chk("lit.rst.we", g_dut[0].obs.reg_write_en, 0);
    chk("lit.rst.busy", g_dut[0].obs.rs1_busy, 0);
    chk("lit.rst.ready0", g_dut[0].obs.req0_ready, 1);
    chk("lit.rst.ready1", g_dut[0].obs.req1_ready, 0);

    // Randomized traffic, each instance with its own protocol-respecting requesters
    for (int c = 0; c < 4000; c++) begin
      next();
      rst = ($urandom_range(0, 299) == 0);
      drive_random(0);
      drive_random(1);
    end

    next();
    rst = 1'b0;
    s = '0;
    set_all(s);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regs_wb_arbiter.md
Name: regs_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: req0 (ALU result) and req1 (load data).
- Keeps a 32-entry pending-write scoreboard so decode can stall on source registers whose producer has not yet written back.
- Sits between the execute/memory stages and the register file write port (reg_write_en / reg_waddr / reg_wdata).
- Output is registered: one write per cycle, one cycle after acceptance.

Parameters:
ADDR_W, 5, register address width (32 registers)
DATA_W, 32, write data width
ROUND_ROBIN, 1, 1 = round-robin between req0/req1; 0 = fixed priority, req0 always wins

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
req0_valid  input  1  ALU writeback request
req0_addr  input  ADDR_W  destination register of req0
req0_data  input  DATA_W  write data of req0
req0_ready  output  1  req0 accepted this cycle
req1_valid  input  1  load writeback request
req1_addr  input  ADDR_W  destination register of req1
req1_data  input  DATA_W  write data of req1
req1_ready  output  1  req1 accepted this cycle
alloc_en  input  1  decode issues an instruction writing alloc_addr
alloc_addr  input  ADDR_W  register to mark pending
rs1_addr  input  ADDR_W  decode source 1
rs2_addr  input  ADDR_W  decode source 2
rs1_busy  output  1  rs1 has an outstanding write
rs2_busy  output  1  rs2 has an outstanding write
reg_write_en  output  1  to register file write enable (registered)
reg_waddr  output  ADDR_W  to register file write address (registered)
reg_wdata  output  DATA_W  to register file write data (registered)

Behaviour:
- Reset (rst=1 at a clk edge):
  - reg_write_en=0, reg_waddr=0, reg_wdata=0.
  - pending[31:0]=0.
  - last_grant=1, so req0 wins the first contest.
  - Reset mid-operation drops any in-flight grant; requesters must re-present.
- Handshake:
  - reqN_ready is combinational and equals grantN.
  - A transfer occurs when reqN_valid & reqN_ready at the edge.
  - A requester must hold valid/addr/data stable until ready.
  - ready is never asserted without valid.
  - No back-pressure from the regfile: the arbiter accepts at most one request every cycle.
- Arbitration:
  - Only one valid: it is granted.
  - Both valid, ROUND_ROBIN=1: grant the requester not equal to last_grant. last_grant updates only on a transfer.
  - Both valid, ROUND_ROBIN=0: grant req0.
  - No valid: no grant; last_grant holds.
- Write port, latency 1:
  - On a transfer: reg_write_en<=1, reg_waddr<=addr, reg_wdata<=data.
  - No transfer: reg_write_en<=0; addr/data hold their previous values.
  - Transfer with addr==0: accepted (ready=1), but reg_write_en<=0.
- Scoreboard:
  - alloc_en with alloc_addr!=0 sets pending[alloc_addr] at the edge.
  - A transfer clears pending[addr] at the same edge.
  - pending[0] is constantly 0.
  - Simultaneous alloc and transfer to the same addr: set wins, because a new producer is outstanding.
  - alloc to an address already pending: stays 1. No counting; the pipeline guarantees in-order writeback per register.
- Busy outputs (combinational):
  - rsN_busy = pending[rsN_addr].
  - rsN_addr==0 gives 0.
  - Because pending clears on the accept edge and the regfile forwards a same-cycle write to its read ports, a reader unstalls exactly when reg_write_en presents the data.

Test Plan:
- Reset, then idle → reg_write_en=0, rs1_busy=rs2_busy=0, req0_ready=req1_ready=0.
- alloc_en=1, alloc_addr=5; next cycle req0_valid=1, addr=5, data=0x1234 → rs1_busy(rs1=5)=1 in the cycle after alloc; req0_ready=1 same cycle; next cycle reg_write_en=1, reg_waddr=5, reg_wdata=0x1234, rs1_busy=0.
- req0 and req1 valid for 4 cycles (addr 3/4, data 0xA/0xB), ROUND_ROBIN=1 → grants 0,1,0,1; reg_waddr sequence 3,4,3,4 each one cycle later. Repeat with ROUND_ROBIN=0 → req0 every cycle, req1_ready=0.
- req1_valid=1, addr=0, data=0xFFFF → req1_ready=1, next cycle reg_write_en=0; alloc_addr=0 → rs1_busy(rs1=0) stays 0.
- pending[7]=1; same cycle alloc_addr=7 and req0 transfer to 7 → pending[7] stays 1, reg_write_en=1 with reg_waddr=7 next cycle.
- Both requests valid, rst=1 for one cycle → ready grant has no effect: reg_write_en=0, pending cleared, next contest granted to req0.
